mips_perf_monitor: RTL and testbench

//   Producer side of the core's performance-counter interface: counts cycles,

---
 rtl/mips_perf_monitor.sv | 116 +++++++++++
 tb/tb_mips_perf_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mips_perf_monitor.sv
// mips_perf_monitor: live performance counters for the mips_16b pipeline
// (cycles, retired instructions, load-use stalls, branch stalls), frozen on
// program halt, with an atomic snapshot streamed as four words over valid/ready.
module mips_perf_monitor #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             retire,
  input  logic             load_stall,
  input  logic             branch_stall,
  input  logic             halt,
  input  logic             snap_req,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] load_stall_count,
  output logic [CNT_W-1:0] branch_stall_count,
  output logic             halted,
  output logic             snap_busy,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [1:0]       rd_idx
);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                 state_q, state_d;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0][CNT_W-1:0]  snap_q, snap_d;
  logic [1:0]             rd_idx_q, rd_idx_d;
  logic                   halted_q, halted_d;
  logic                   auto_pend_q, auto_pend_d;

  logic                   count_en;
  logic [3:0]             events;
  logic                   start;

  // Counter increments: index 0 counts every enabled cycle, 1..3 count events
  always_comb begin
    count_en = clk_en & ~halted_q;
    events   = {branch_stall, load_stall, retire, 1'b1};
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(count_en & events[i]);
    end
  end

  // Sticky halt plus the auto-snapshot request it raises; a pending request
  // survives an in-progress dump and is consumed when a new dump starts
  always_comb begin
    halted_d    = halted_q | (clk_en & halt);
    start       = (state_q == IDLE) & (snap_req | auto_pend_q);
    auto_pend_d = (halted_d & ~halted_q) | (auto_pend_q & ~start);
  end

  // Readout FSM: capture snapshot on start, step through four words on handshakes
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    rd_idx_d = rd_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          snap_d   = cnt_q;
          rd_idx_d = '0;
        end
      end
      STREAM: begin
        if (rd_ready) begin
          if (rd_idx_q == 2'd3) begin
            state_d  = IDLE;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      snap_q      <= '0;
      rd_idx_q    <= '0;
      halted_q    <= 1'b0;
      auto_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      rd_idx_q    <= rd_idx_d;
      halted_q    <= halted_d;
      auto_pend_q <= auto_pend_d;
    end
  end

  // Output mapping
  always_comb begin
    cycle_count        = cnt_q[0];
    instr_count        = cnt_q[1];
    load_stall_count   = cnt_q[2];
    branch_stall_count = cnt_q[3];
    halted             = halted_q;
    snap_busy          = (state_q == STREAM);
    rd_valid           = (state_q == STREAM);
    rd_idx             = rd_idx_q;
    rd_data            = snap_q[rd_idx_q];
  end

endmodule

// File: tb/tb_mips_perf_monitor.sv
// Directed bench for mips_perf_monitor: a 32-bit instance for counting,
// snapshot readout and halt, and a 4-bit instance for wrap and mid-dump reset.
module tb_mips_perf_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // 32-bit instance
  logic        reset, clk_en, retire, load_stall, branch_stall, halt, snap_req, rd_ready;
  logic [31:0] cycle_count, instr_count, load_stall_count, branch_stall_count, rd_data;
  logic        halted, snap_busy, rd_valid;
  logic [1:0]  rd_idx;

  mips_perf_monitor #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .retire(retire),
    .load_stall(load_stall), .branch_stall(branch_stall), .halt(halt),
    .snap_req(snap_req), .rd_ready(rd_ready),
    .cycle_count(cycle_count), .instr_count(instr_count),
    .load_stall_count(load_stall_count), .branch_stall_count(branch_stall_count),
    .halted(halted), .snap_busy(snap_busy), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_idx(rd_idx)
  );

  // 4-bit instance
  logic       reset_b, clk_en_b, retire_b, snap_req_b, rd_ready_b;
  logic [3:0] cycle_count_b, instr_count_b, load_stall_count_b, branch_stall_count_b, rd_data_b;
  logic       halted_b, snap_busy_b, rd_valid_b;
  logic [1:0] rd_idx_b;

  mips_perf_monitor #(.CNT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .clk_en(clk_en_b), .retire(retire_b),
    .load_stall(1'b0), .branch_stall(1'b0), .halt(1'b0),
    .snap_req(snap_req_b), .rd_ready(rd_ready_b),
    .cycle_count(cycle_count_b), .instr_count(instr_count_b),
    .load_stall_count(load_stall_count_b), .branch_stall_count(branch_stall_count_b),
    .halted(halted_b), .snap_busy(snap_busy_b), .rd_valid(rd_valid_b),
    .rd_data(rd_data_b), .rd_idx(rd_idx_b)
  );

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; retire = 1'b0; load_stall = 1'b0;
    branch_stall = 1'b0; halt = 1'b0; snap_req = 1'b0; rd_ready = 1'b0;
    reset_b = 1'b1; clk_en_b = 1'b0; retire_b = 1'b0; snap_req_b = 1'b0; rd_ready_b = 1'b0;
    #2;
    tick(2);

    // Reset state
    chk("rst_cycle", cycle_count, 0);
    chk("rst_instr", instr_count, 0);
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_busy", {31'd0, snap_busy}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_idx", {30'd0, rd_idx}, 0);
    reset = 1'b0;

    // T1: 10 enabled cycles, retiring every cycle
    clk_en = 1'b1; retire = 1'b1;
    tick(10);
    chk("t1_cycle", cycle_count, 10);
    chk("t1_instr", instr_count, 10);

    // T2: disabled clock, all events high
    clk_en = 1'b0; retire = 1'b1; load_stall = 1'b1; branch_stall = 1'b1;
    tick(5);
    chk("t2_cycle", cycle_count, 10);
    chk("t2_instr", instr_count, 10);
    chk("t2_load", load_stall_count, 0);
    chk("t2_branch", branch_stall_count, 0);

    // T3: 3 load stalls, 2 branch stalls, one cycle with both
    clk_en = 1'b1; retire = 1'b0;
    load_stall = 1'b1; branch_stall = 1'b0; tick();
    load_stall = 1'b1; branch_stall = 1'b1; tick();
    load_stall = 1'b1; branch_stall = 1'b0; tick();
    load_stall = 1'b0; branch_stall = 1'b1; tick();
    branch_stall = 1'b0;
    chk("t3_load", load_stall_count, 3);
    chk("t3_branch", branch_stall_count, 2);
    chk("t3_cycle", cycle_count, 14);
    chk("t3_instr", instr_count, 10);

    // T4: snapshot at cycle_count=20 with reader back-pressure
    tick(6);
    chk("t4_pre_cycle", cycle_count, 20);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("t4_valid", {31'd0, rd_valid}, 1);
    chk("t4_busy", {31'd0, snap_busy}, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t4_hold_idx", {30'd0, rd_idx}, 0);
      chk("t4_hold_data", rd_data, 20);
      tick();
    end
    chk("t4_hold_idx_end", {30'd0, rd_idx}, 0);
    chk("t4_hold_data_end", rd_data, 20);
    rd_ready = 1'b1;
    tick();
    chk("t4_idx1", {30'd0, rd_idx}, 1);
    chk("t4_w1", rd_data, 10);
    tick();
    chk("t4_idx2", {30'd0, rd_idx}, 2);
    chk("t4_w2", rd_data, 3);
    tick();
    chk("t4_idx3", {30'd0, rd_idx}, 3);
    chk("t4_w3", rd_data, 2);
    snap_req = 1'b1;  // arrives with the final handshake: must be dropped
    tick();
    snap_req = 1'b0;
    chk("t4_done_valid", {31'd0, rd_valid}, 0);
    chk("t4_done_busy", {31'd0, snap_busy}, 0);
    chk("t4_done_idx", {30'd0, rd_idx}, 0);
    tick();
    chk("t4_ignored_req", {31'd0, rd_valid}, 0);
    chk("t4_live_cycle", cycle_count, 30);
    rd_ready = 1'b0;

    // T5: halt on the 57th enabled cycle, auto dump
    tick(26);
    chk("t5_pre_cycle", cycle_count, 56);
    halt = 1'b1; retire = 1'b1; tick();
    halt = 1'b0; retire = 1'b0;
    chk("t5_cycle", cycle_count, 57);
    chk("t5_instr", instr_count, 11);
    chk("t5_halted", {31'd0, halted}, 1);
    chk("t5_not_yet_valid", {31'd0, rd_valid}, 0);
    retire = 1'b1; tick(); retire = 1'b0;
    chk("t5_auto_valid", {31'd0, rd_valid}, 1);
    chk("t5_auto_w0", rd_data, 57);
    chk("t5_frozen_cycle", cycle_count, 57);
    chk("t5_frozen_instr", instr_count, 11);
    rd_ready = 1'b1;
    tick();
    chk("t5_auto_w1", rd_data, 11);
    tick(3);
    rd_ready = 1'b0;
    chk("t5_auto_done", {31'd0, rd_valid}, 0);
    tick(3);
    chk("t5_no_redump", {31'd0, rd_valid}, 0);
    chk("t5_still_halted", {31'd0, halted}, 1);

    // T6: 4-bit wrap and reset during a dump
    reset_b = 1'b0; clk_en_b = 1'b1; retire_b = 1'b1;
    tick(17);
    chk("t6_wrap_cycle", {28'd0, cycle_count_b}, 1);
    chk("t6_wrap_instr", {28'd0, instr_count_b}, 1);
    snap_req_b = 1'b1; tick(); snap_req_b = 1'b0;
    chk("t6_w0", {28'd0, rd_data_b}, 1);
    rd_ready_b = 1'b1;
    tick(2);
    chk("t6_idx2", {30'd0, rd_idx_b}, 2);
    chk("t6_idx2_valid", {31'd0, rd_valid_b}, 1);
    reset_b = 1'b1; tick();
    chk("t6_rst_valid", {31'd0, rd_valid_b}, 0);
    chk("t6_rst_cycle", {28'd0, cycle_count_b}, 0);
    chk("t6_rst_instr", {28'd0, instr_count_b}, 0);
    chk("t6_rst_idx", {30'd0, rd_idx_b}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
